l1_dcache: RTL and testbench

L1_DCACHE -- requirements
Module: l1_dcache

---
 rtl/lc3b_types.sv | 29 ++
 rtl/dcache_control.sv | 87 ++++++++
 rtl/l1_dcache.sv | 124 ++++++++++++
 tb/tb_l1_dcache.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the L1 data cache.
// Provides the cache line / tag / index / offset types, the cache
// controller state encoding and a byte-merge helper for store hits.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [1:0]   lc3b_mem_wmask;
   typedef logic [127:0] lc3b_cache_line;
   typedef logic [8:0]   lc3b_cache_tag;
   typedef logic [2:0]   lc3b_cache_index;
   typedef logic [3:0]   lc3b_cache_offset;

   localparam int DCACHE_SETS = 8;

   typedef enum logic [1:0] {
      DC_IDLE,
      DC_WRITEBACK,
      DC_ALLOCATE
   } dcache_state_t;

   // Replace the bytes of 'old_w' selected by 'mask' ([1] = high byte).
   function automatic lc3b_word byte_merge(input lc3b_word old_w,
                                           input lc3b_word new_w,
                                           input lc3b_mem_wmask mask);
      byte_merge = {mask[1] ? new_w[15:8] : old_w[15:8],
                    mask[0] ? new_w[7:0]  : old_w[7:0]};
   endfunction

endpackage

// File: rtl/dcache_control.sv
// Miss-handling FSM for the L1 data cache (IDLE / WRITEBACK / ALLOCATE).
// Ports:
//   clk, reset_n          clock, async active-low reset
//   mem_read, mem_write   MEM-stage request strobes
//   hit                   indexed set is valid with matching tag
//   victim_dirty          indexed set is valid and dirty
//   pmem_resp             physical memory completion pulse
//   dcache_resp           1 = request done / no request, 0 = stall
//   pmem_read, pmem_write registered physical memory strobes
//   miss_start            IDLE miss; the datapath latches the line address
//   load_line             fill data is valid this cycle, write it to the set
//   data_we               store hit, merge write data this cycle
module dcache_control
   import lc3b_types::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic mem_read,
   input  logic mem_write,
   input  logic hit,
   input  logic victim_dirty,
   input  logic pmem_resp,
   output logic dcache_resp,
   output logic pmem_read,
   output logic pmem_write,
   output logic miss_start,
   output logic load_line,
   output logic data_we
);

   dcache_state_t state;
   logic          req;
   logic          is_idle;

   assign req     = mem_read | mem_write;
   assign is_idle = (state == DC_IDLE);

   // Zero-cycle hit path: response is purely combinational in IDLE.
   assign dcache_resp = is_idle & (~req | hit);
   assign miss_start  = is_idle & req & ~hit;
   assign data_we     = is_idle & mem_write & hit;
   assign load_line   = (state == DC_ALLOCATE) & pmem_resp;

   // Strobes are registered alongside the state so they are asserted for
   // exactly the cycles spent in WRITEBACK / ALLOCATE. The request is not
   // consulted once a miss is in flight, so a withdrawn request still fills.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= DC_IDLE;
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
      end else begin
         case (state)
            DC_IDLE: begin
               if (miss_start) begin
                  if (victim_dirty) begin
                     state      <= DC_WRITEBACK;
                     pmem_write <= 1'b1;
                  end else begin
                     state     <= DC_ALLOCATE;
                     pmem_read <= 1'b1;
                  end
               end
            end
            DC_WRITEBACK: begin
               if (pmem_resp) begin
                  state      <= DC_ALLOCATE;
                  pmem_write <= 1'b0;
                  pmem_read  <= 1'b1;
               end
            end
            DC_ALLOCATE: begin
               if (pmem_resp) begin
                  state     <= DC_IDLE;
                  pmem_read <= 1'b0;
               end
            end
            default: begin
               state      <= DC_IDLE;
               pmem_read  <= 1'b0;
               pmem_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back L1 data cache: 8 sets x 16-byte lines.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   mem_read/mem_write           MEM-stage load / store request
//   mem_address, mem_wdata       byte address, store data
//   mem_byte_enable              store byte lanes, [1] = high byte
//   mem_rdata                    selected word of the indexed line
//   dcache_resp                  1 = done or idle, 0 = stall MEM
//   pmem_read/pmem_write         line fill / writeback strobes
//   pmem_address                 line address (low nibble zero), 0 when idle
//   pmem_wdata, pmem_rdata       victim line out, fill line in
//   pmem_resp                    physical memory completion pulse
module l1_dcache
   import lc3b_types::*;
(
   input  logic           clk,
   input  logic           reset_n,
   input  logic           mem_read,
   input  logic           mem_write,
   input  logic [15:0]    mem_address,
   input  logic [15:0]    mem_wdata,
   input  logic [1:0]     mem_byte_enable,
   output logic [15:0]    mem_rdata,
   output logic           dcache_resp,
   output logic           pmem_read,
   output logic           pmem_write,
   output logic [15:0]    pmem_address,
   output logic [127:0]   pmem_wdata,
   input  logic [127:0]   pmem_rdata,
   input  logic           pmem_resp
);

   logic [DCACHE_SETS-1:0] valid_arr;
   logic [DCACHE_SETS-1:0] dirty_arr;
   lc3b_cache_tag          tag_arr  [DCACHE_SETS];
   lc3b_cache_line         data_arr [DCACHE_SETS];

   lc3b_cache_tag    req_tag;
   lc3b_cache_index  req_index;
   lc3b_cache_offset req_offset;
   logic [2:0]       word_sel;
   logic             unused_byte_sel;

   assign req_tag         = mem_address[15:7];
   assign req_index       = mem_address[6:4];
   assign req_offset      = mem_address[3:0];
   assign word_sel        = req_offset[3:1];
   assign unused_byte_sel = req_offset[0];   // loads/stores are word aligned

   logic hit, victim_dirty, miss_start, load_line, data_we;

   assign hit          = valid_arr[req_index] & (tag_arr[req_index] == req_tag);
   assign victim_dirty = valid_arr[req_index] & dirty_arr[req_index];

   // Line address of the outstanding miss, captured when it starts so the
   // fill lands in the right set even if the request is dropped meanwhile.
   logic [11:0]     miss_line;
   lc3b_cache_tag   miss_tag;
   lc3b_cache_index miss_index;

   assign miss_tag   = miss_line[11:3];
   assign miss_index = miss_line[2:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         miss_line <= '0;
      else if (miss_start)
         miss_line <= mem_address[15:4];
   end

   dcache_control u_control (
      .clk          (clk),
      .reset_n      (reset_n),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .hit          (hit),
      .victim_dirty (victim_dirty),
      .pmem_resp    (pmem_resp),
      .dcache_resp  (dcache_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .miss_start   (miss_start),
      .load_line    (load_line),
      .data_we      (data_we)
   );

   // Read path: always the selected word of the indexed line.
   lc3b_word cur_word;
   assign cur_word  = data_arr[req_index][{word_sel, 4'b0000} +: 16];
   assign mem_rdata = cur_word;

   // Writeback address uses the stored (victim) tag, fill uses the miss tag.
   always_comb begin
      pmem_address = '0;
      if (pmem_write)
         pmem_address = {tag_arr[miss_index], miss_index, 4'b0000};
      else if (pmem_read)
         pmem_address = {miss_tag, miss_index, 4'b0000};
   end

   assign pmem_wdata = data_arr[miss_index];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_arr <= '0;
         dirty_arr <= '0;
         for (int i = 0; i < DCACHE_SETS; i++) begin
            tag_arr[i]  <= '0;
            data_arr[i] <= '0;
         end
      end else if (load_line) begin
         data_arr[miss_index]  <= pmem_rdata;
         tag_arr[miss_index]   <= miss_tag;
         valid_arr[miss_index] <= 1'b1;
         dirty_arr[miss_index] <= 1'b0;
      end else if (data_we) begin
         // A store with no lanes enabled still marks the line dirty.
         data_arr[req_index][{word_sel, 4'b0000} +: 16] <=
            byte_merge(cur_word, mem_wdata, mem_byte_enable);
         dirty_arr[req_index] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache with a latency-3 physical memory model.
module tb_l1_dcache;

   localparam int LAT = 3;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         mem_read = 1'b0, mem_write = 1'b0;
   logic [15:0]  mem_address = '0, mem_wdata = '0;
   logic [1:0]   mem_byte_enable = '0;
   logic [15:0]  mem_rdata;
   logic         dcache_resp;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata = '0;
   logic         pmem_resp = 1'b0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit           is_wr;
      logic [15:0]  addr;
      logic [127:0] data;
   } pm_t;

   pm_t          obs_q[$];
   pm_t          exp_pm_q[$];
   logic [15:0]  exp_rd_q[$];
   logic [127:0] mem_model [logic [15:0]];
   int           pm_cnt = 0;
   bit           spur = 1'b0;

   always #5 clk = ~clk;

   l1_dcache dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_rdata       (mem_rdata),
      .dcache_resp     (dcache_resp),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_address    (pmem_address),
      .pmem_wdata      (pmem_wdata),
      .pmem_rdata      (pmem_rdata),
      .pmem_resp       (pmem_resp)
   );

   // Physical memory: answers LAT cycles after a strobe appears, logging
   // each completed transaction to obs_q.
   always @(negedge clk) begin
      if (!reset_n) begin
         pmem_resp = 1'b0;
         pm_cnt    = 0;
      end else if (pmem_resp) begin
         pmem_resp = 1'b0;
         pm_cnt    = 0;
      end else if (pmem_read || pmem_write) begin
         checks++;
         if (pmem_read && pmem_write) begin
            errors++;
            $display("FAIL strobe_exclusive: read=%b write=%b, required not both", pmem_read, pmem_write);
         end
         pm_cnt++;
         if (pm_cnt == LAT) begin
            if (pmem_write) begin
               obs_q.push_back('{1'b1, pmem_address, pmem_wdata});
               mem_model[pmem_address] = pmem_wdata;
            end else begin
               obs_q.push_back('{1'b0, pmem_address, 128'h0});
               pmem_rdata = mem_model.exists(pmem_address) ? mem_model[pmem_address] : 128'h0;
            end
            pmem_resp = 1'b1;
         end
      end else begin
         pmem_resp = spur;
      end
   end

   // Drives one request, waits (bounded) for dcache_resp, returns the
   // sampled load data and the number of stalled cycles.
   task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                         input logic [15:0] wd, input logic [1:0] be,
                         output logic [15:0] rdata, output int stall);
      mem_read = rd; mem_write = wr; mem_address = a;
      mem_wdata = wd; mem_byte_enable = be;
      stall = 0;
      forever begin
         @(negedge clk);
         if (dcache_resp) break;
         stall++;
         if (stall > 200) begin
            checks++; errors++;
            $display("FAIL access_timeout: addr=%h no dcache_resp after %0d cycles", a, stall);
            break;
         end
      end
      rdata = mem_rdata;
      @(posedge clk);
      #1 mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({dcache_resp, pmem_read, pmem_write} !== 3'b100) begin
         errors++;
         $display("FAIL reset_strobes: resp/rd/wr=%b, required 100", {dcache_resp, pmem_read, pmem_write});
      end
      checks++;
      if ({mem_rdata, pmem_address} !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: rdata=%h paddr=%h, required 0", mem_rdata, pmem_address);
      end
      checks++;
      if (pmem_wdata !== 128'h0) begin
         errors++;
         $display("FAIL reset_wdata: got %h, required 0", pmem_wdata);
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // Pops one observed pmem transaction and compares with the expected one.
   // Inlined per test through this macro-free loop pattern.
   task automatic test_read_miss();
      logic [15:0] rd; int st; pm_t e, o;
      exp_pm_q.push_back('{1'b0, 16'h0040, 128'h0});
      exp_rd_q.push_back(16'hBEEF);
      access(1, 0, 16'h0042, 16'h0, 2'b00, rd, st);
      checks++;
      if (st !== LAT + 1) begin
         errors++; $display("FAIL clean_miss_latency: got %0d, required %0d", st, LAT + 1);
      end
      checks++;
      if (rd !== exp_rd_q.pop_front()) begin
         errors++; $display("FAIL read_miss_data: got %h, required beef", rd);
      end
      while (exp_pm_q.size() > 0) begin
         e = exp_pm_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++; $display("FAIL read_miss_pmem: no transaction observed, required addr %h", e.addr);
         end else begin
            o = obs_q.pop_front();
            if (o.is_wr !== e.is_wr || o.addr !== e.addr) begin
               errors++; $display("FAIL read_miss_pmem: wr=%b addr=%h, required wr=%b addr=%h", o.is_wr, o.addr, e.is_wr, e.addr);
            end
         end
      end
   endtask

   task automatic test_write_hit();
      logic [15:0] rd; int st;
      access(0, 1, 16'h0042, 16'h1234, 2'b01, rd, st);
      checks++;
      if (st !== 0) begin
         errors++; $display("FAIL write_hit_latency: got %0d, required 0", st);
      end
      exp_rd_q.push_back(16'hBE34);
      exp_rd_q.push_back(16'hBE34);
      access(1, 0, 16'h0042, 16'h0, 2'b00, rd, st);
      checks++;
      if (rd !== exp_rd_q.pop_front() || st !== 0) begin
         errors++; $display("FAIL write_hit_readback: got %h stall %0d, required be34 stall 0", rd, st);
      end
      // Odd byte address selects the same word.
      access(1, 0, 16'h0043, 16'h0, 2'b00, rd, st);
      checks++;
      if (rd !== exp_rd_q.pop_front() || st !== 0) begin
         errors++; $display("FAIL odd_addr_read: got %h stall %0d, required be34 stall 0", rd, st);
      end
   endtask

   task automatic test_writeback();
      logic [15:0] rd; int st; pm_t e, o;
      exp_pm_q.push_back('{1'b1, 16'h0040, 128'h7777_6666_5555_4444_3333_2222_BE34_1111});
      exp_pm_q.push_back('{1'b0, 16'h00C0, 128'h0});
      exp_rd_q.push_back(16'hC000);
      access(1, 0, 16'h00C0, 16'h0, 2'b00, rd, st);
      checks++;
      if (st !== 2 * LAT + 2) begin
         errors++; $display("FAIL dirty_miss_latency: got %0d, required %0d", st, 2 * LAT + 2);
      end
      checks++;
      if (rd !== exp_rd_q.pop_front()) begin
         errors++; $display("FAIL dirty_miss_data: got %h, required c000", rd);
      end
      // Evict the now-clean line and refetch the written-back data.
      exp_pm_q.push_back('{1'b0, 16'h0040, 128'h0});
      exp_rd_q.push_back(16'hBE34);
      access(1, 0, 16'h0042, 16'h0, 2'b00, rd, st);
      checks++;
      if (rd !== exp_rd_q.pop_front() || st !== LAT + 1) begin
         errors++; $display("FAIL refetch: got %h stall %0d, required be34 stall %0d", rd, st, LAT + 1);
      end
      while (exp_pm_q.size() > 0) begin
         e = exp_pm_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++; $display("FAIL writeback_pmem: no transaction observed, required addr %h", e.addr);
         end else begin
            o = obs_q.pop_front();
            if (o.is_wr !== e.is_wr || o.addr !== e.addr || (e.is_wr && o.data !== e.data)) begin
               errors++; $display("FAIL writeback_pmem: wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h", o.is_wr, o.addr, o.data, e.is_wr, e.addr, e.data);
            end
         end
      end
   endtask

   task automatic test_idle();
      logic [15:0] rd; int st; int bad = 0;
      for (int i = 0; i < 10; i++) begin
         spur = (i == 4);
         @(negedge clk);
         if ({dcache_resp, pmem_read, pmem_write} !== 3'b100) bad++;
      end
      spur = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL idle_quiet: %0d bad cycles, required 0", bad);
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++; $display("FAIL idle_no_pmem: %0d transactions, required 0", obs_q.size());
      end
      @(posedge clk); #1;
      exp_rd_q.push_back(16'hBE34);
      access(1, 0, 16'h0042, 16'h0, 2'b00, rd, st);
      checks++;
      if (rd !== exp_rd_q.pop_front() || st !== 0) begin
         errors++; $display("FAIL after_spurious: got %h stall %0d, required be34 stall 0", rd, st);
      end
   endtask

   task automatic test_reset_mid_alloc();
      logic [15:0] rd; int st; int n = 0; pm_t o;
      mem_read = 1'b1; mem_address = 16'h0106;
      do begin
         @(negedge clk); n++;
      end while (!pmem_read && n < 20);
      checks++;
      if (!pmem_read) begin
         errors++; $display("FAIL abort_setup: pmem_read never rose");
      end
      #1 reset_n = 1'b0; mem_read = 1'b0;
      #1;
      checks++;
      if (pmem_read !== 1'b0 || pmem_address !== 16'h0) begin
         errors++; $display("FAIL abort_drop: pmem_read=%b paddr=%h, required 0/0000", pmem_read, pmem_address);
      end
      @(posedge clk); @(posedge clk);
      #1 reset_n = 1'b1;
      checks++;
      if (obs_q.size() != 0) begin
         errors++; $display("FAIL abort_no_txn: %0d transactions, required 0", obs_q.size());
      end
      exp_pm_q.push_back('{1'b0, 16'h0100, 128'h0});
      exp_rd_q.push_back(16'h2103);
      access(1, 0, 16'h0106, 16'h0, 2'b00, rd, st);
      checks++;
      if (rd !== exp_rd_q.pop_front() || st !== LAT + 1) begin
         errors++; $display("FAIL reread_after_reset: got %h stall %0d, required 2103 stall %0d", rd, st, LAT + 1);
      end
      checks++;
      if (obs_q.size() == 0) begin
         errors++; $display("FAIL reread_pmem: no transaction observed, required read 0100");
         void'(exp_pm_q.pop_front());
      end else begin
         o = obs_q.pop_front();
         if (o.is_wr !== exp_pm_q[0].is_wr || o.addr !== exp_pm_q[0].addr) begin
            errors++; $display("FAIL reread_pmem: wr=%b addr=%h, required read 0100", o.is_wr, o.addr);
         end
         void'(exp_pm_q.pop_front());
      end
   endtask

   task automatic test_rw_miss();
      logic [15:0] rd; int st; pm_t e, o;
      exp_pm_q.push_back('{1'b0, 16'h0010, 128'h0});
      access(1, 1, 16'h0010, 16'h5A5A, 2'b11, rd, st);
      checks++;
      if (st !== LAT + 1) begin
         errors++; $display("FAIL rw_miss_latency: got %0d, required %0d", st, LAT + 1);
      end
      exp_rd_q.push_back(16'h5A5A);
      access(1, 0, 16'h0010, 16'h0, 2'b00, rd, st);
      checks++;
      if (rd !== exp_rd_q.pop_front() || st !== 0) begin
         errors++; $display("FAIL rw_applied: got %h stall %0d, required 5a5a stall 0", rd, st);
      end
      exp_pm_q.push_back('{1'b1, 16'h0010, 128'h1007_1006_1005_1004_1003_1002_1001_5A5A});
      exp_pm_q.push_back('{1'b0, 16'h0090, 128'h0});
      exp_rd_q.push_back(16'h9000);
      access(1, 0, 16'h0090, 16'h0, 2'b00, rd, st);
      checks++;
      if (rd !== exp_rd_q.pop_front() || st !== 2 * LAT + 2) begin
         errors++; $display("FAIL rw_dirty_evict: got %h stall %0d, required 9000 stall %0d", rd, st, 2 * LAT + 2);
      end
      // Back-to-back store hits: empty mask, then high byte only.
      access(0, 1, 16'h0092, 16'hFFFF, 2'b00, rd, st);
      access(0, 1, 16'h0095, 16'hAB12, 2'b10, rd, st);
      checks++;
      if (st !== 0) begin
         errors++; $display("FAIL store_hit_b2b: stall %0d, required 0", st);
      end
      exp_pm_q.push_back('{1'b1, 16'h0090, 128'h9007_9006_9005_9004_9003_AB02_9001_9000});
      exp_pm_q.push_back('{1'b0, 16'h0010, 128'h0});
      exp_rd_q.push_back(16'h5A5A);
      access(1, 0, 16'h0010, 16'h0, 2'b00, rd, st);
      checks++;
      if (rd !== exp_rd_q.pop_front() || st !== 2 * LAT + 2) begin
         errors++; $display("FAIL mask_dirty_evict: got %h stall %0d, required 5a5a stall %0d", rd, st, 2 * LAT + 2);
      end
      while (exp_pm_q.size() > 0) begin
         e = exp_pm_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++; $display("FAIL rw_pmem: no transaction observed, required addr %h", e.addr);
         end else begin
            o = obs_q.pop_front();
            if (o.is_wr !== e.is_wr || o.addr !== e.addr || (e.is_wr && o.data !== e.data)) begin
               errors++; $display("FAIL rw_pmem: wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h", o.is_wr, o.addr, o.data, e.is_wr, e.addr, e.data);
            end
         end
      end
   endtask

   initial begin
      mem_model[16'h0040] = 128'h7777_6666_5555_4444_3333_2222_BEEF_1111;
      mem_model[16'h00C0] = 128'hC777_C666_C555_C444_C333_C222_C111_C000;
      mem_model[16'h0100] = 128'h2107_2106_2105_2104_2103_2102_2101_2100;
      mem_model[16'h0010] = 128'h1007_1006_1005_1004_1003_1002_1001_1000;
      mem_model[16'h0090] = 128'h9007_9006_9005_9004_9003_9002_9001_9000;
      test_reset();
      test_read_miss();
      test_write_hit();
      test_writeback();
      test_idle();
      test_reset_mid_alloc();
      test_rw_miss();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
